pmem_responder: RTL and testbench

Synthesizable physical-memory responder that sits on the far side of the CPU top's `pmem_*` port, on the L2 cache's physical-memory interface. It accepts single block reads and writes from the L2 cache and answers each one after a programmable latency with a one-cycle `pmem_resp` pulse. It also polices the request handshake and records violations in a sticky error flag. It serves as the memory model for system-level benches and as the template for a board memory controller.

---
 rtl/pmem_responder.sv | 122 ++++++++++++
 tb/tb_pmem_responder.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/pmem_responder.sv
// Block-granular physical memory model for the L2 side of the CPU: serves one
// read or write at a time after a fixed latency and flags handshake violations.
module pmem_responder #(
    parameter int BLOCK_BITS  = 256,
    parameter int OFFSET_BITS = 5,
    parameter int LATENCY     = 10,
    parameter     INIT_FILE   = ""
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pmem_read,
    input  logic                  pmem_write,
    input  logic [15:0]           pmem_address,
    input  logic [BLOCK_BITS-1:0] pmem_wdata,
    output logic                  pmem_resp,
    output logic [BLOCK_BITS-1:0] pmem_rdata,
    output logic                  protocol_error,
    output logic                  busy
);

    localparam int IDX_W = 16 - OFFSET_BITS;
    localparam int DEPTH = 1 << IDX_W;
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESPOND
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [CNT_W-1:0]        count;
    logic                    op_write;
    logic [IDX_W-1:0]        idx;
    logic [BLOCK_BITS-1:0]   wdata_q;
    logic [BLOCK_BITS-1:0]   mem [DEPTH];

    logic                    accept;
    logic                    commit;
    logic                    load_rdata;
    logic                    err_set;
    logic                    req_write;
    logic [IDX_W-1:0]        req_idx;
    logic                    unused_offset;

    // A simultaneous read+write is treated as a read, so only a pure write counts as one.
    assign req_write     = pmem_write & ~pmem_read;
    assign req_idx       = pmem_address[15:OFFSET_BITS];
    assign unused_offset = ^pmem_address[OFFSET_BITS-1:0];

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        commit     = 1'b0;
        load_rdata = 1'b0;
        err_set    = 1'b0;
        case (state)
            IDLE: begin
                if (pmem_read || pmem_write) begin
                    accept     = 1'b1;
                    err_set    = pmem_read & pmem_write;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (!pmem_read && !pmem_write) begin
                    err_set    = 1'b1;
                    state_next = IDLE;
                end else begin
                    err_set = (req_write != op_write) || (req_idx != idx);
                    if (count == '0) begin
                        commit     = op_write;
                        load_rdata = ~op_write;
                        state_next = RESPOND;
                    end
                end
            end
            RESPOND: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            count          <= '0;
            protocol_error <= 1'b0;
            pmem_rdata     <= '0;
        end else begin
            state <= state_next;
            if (accept)
                count <= CNT_LOAD;
            else if (state == BUSY && count != '0)
                count <= count - 1'b1;
            if (err_set)
                protocol_error <= 1'b1;
            if (load_rdata)
                pmem_rdata <= mem[idx];
        end
    end

    // Captured request and storage carry no reset; the array survives reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_write <= req_write;
            idx      <= req_idx;
            wdata_q  <= pmem_wdata;
        end
        if (commit)
            mem[idx] <= wdata_q;
    end

    assign pmem_resp = (state == RESPOND);
    assign busy      = (state == BUSY) || (state == RESPOND);

endmodule

// File: tb/tb_pmem_responder.sv
// Scoreboarded random/directed bench for pmem_responder: instance a at latency 10,
// instance b at latency 1 for the back-to-back minimum-latency case.
module tb_pmem_responder;

    localparam int LAT_A = 10;
    localparam int LAT_B = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic         rst_a, ra, wa, resp_a, err_a, busy_a;
    logic [15:0]  aa;
    logic [255:0] wda, rdata_a;
    logic         rst_b, rb, wb, resp_b, err_b, busy_b;
    logic [15:0]  ab;
    logic [255:0] wdb, rdata_b;

    pmem_responder #(.BLOCK_BITS(256), .OFFSET_BITS(5), .LATENCY(LAT_A)) dut_a (
        .clk(clk), .reset(rst_a), .pmem_read(ra), .pmem_write(wa),
        .pmem_address(aa), .pmem_wdata(wda), .pmem_resp(resp_a),
        .pmem_rdata(rdata_a), .protocol_error(err_a), .busy(busy_a));

    pmem_responder #(.BLOCK_BITS(256), .OFFSET_BITS(5), .LATENCY(LAT_B)) dut_b (
        .clk(clk), .reset(rst_b), .pmem_read(rb), .pmem_write(wb),
        .pmem_address(ab), .pmem_wdata(wdb), .pmem_resp(resp_b),
        .pmem_rdata(rdata_b), .protocol_error(err_b), .busy(busy_b));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Reference memory: whole blocks keyed by block number, zero when never written.
    logic [255:0] model [int];

    function automatic logic [255:0] model_get(input logic [15:0] addr);
        int k = int'(addr >> 5);
        return model.exists(k) ? model[k] : 256'd0;
    endfunction

    function automatic logic [255:0] rand_blk();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    typedef struct {
        bit           rd;
        logic [255:0] data;
        int           cyc;
    } exp_t;
    exp_t sbq[$];

    int nresp_a = 0;
    bit prev_resp_a = 1'b0;

    // Monitor: every response must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (resp_a) begin
            nresp_a++;
            total++;
            if (sbq.size() == 0) begin
                bad++;
                $display("FAIL spurious_resp: got pulse at cycle %0d want none", cyc);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                if (cyc != e.cyc) begin
                    bad++;
                    $display("FAIL resp_cycle: got %0d want %0d", cyc, e.cyc);
                end
                if (e.rd) chk("rdata", rdata_a, e.data);
            end
            chk("resp_width", prev_resp_a, 1'b0);
        end
        prev_resp_a = resp_a;
    end

    // Call just after a rising edge with instance a idle.
    task automatic issue(input bit rd, input bit wr, input logic [15:0] addr, input logic [255:0] wd);
        exp_t e;
        bit   got = 1'b0;
        ra = rd; wa = wr; aa = addr; wda = wd;
        e.rd  = rd;
        e.cyc = cyc + 1 + LAT_A;
        if (rd) begin
            e.data = model_get(addr);
        end else begin
            e.data = '0;
            model[int'(addr >> 5)] = wd;
        end
        sbq.push_back(e);
        for (int i = 0; i < LAT_A + 6 && !got; i++) begin
            @(negedge clk);
            if (resp_a) got = 1'b1;
        end
        chk("resp_seen", got, 1'b1);
        ra = 1'b0; wa = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        int n0;
        int pulses[$];
        int base;
        rst_a = 0; ra = 0; wa = 0; aa = '0; wda = '0;
        rst_b = 0; rb = 0; wb = 0; ab = 16'h0040; wdb = '0;

        // Reset values with no clock edge yet
        #1 rst_a = 1; rst_b = 1;
        #1;
        chk("rst_resp", resp_a, 1'b0);
        chk("rst_busy", busy_a, 1'b0);
        chk("rst_err", err_a, 1'b0);
        chk("rst_rdata", rdata_a, '0);
        chk("rst_busy_b", busy_b, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_a = 0; rst_b = 0;
        @(posedge clk); #1;

        // Write then read the same block through a different offset
        issue(0, 1, 16'h1234, {{31{8'hA5}}, 8'h01});
        issue(1, 0, 16'h1220, '0);
        chk("rdata_hold", rdata_a, {{31{8'hA5}}, 8'h01});

        // Random legal traffic over a handful of blocks
        for (int t = 0; t < 30; t++) begin
            logic [15:0] a;
            a = {11'(16'h0100 + $urandom_range(0, 7)), 5'($urandom)};
            if ($urandom_range(0, 1) == 1) issue(1, 0, a, '0);
            else                           issue(0, 1, a, rand_blk());
        end
        chk("err_clean", err_a, 1'b0);

        // Abort: write dropped three cycles in
        n0 = nresp_a;
        wa = 1; aa = 16'h1234; wda = rand_blk();
        repeat (3) @(posedge clk);
        #1 wa = 0;
        repeat (LAT_A + 4) @(posedge clk);
        #1;
        chk("abort_err", err_a, 1'b1);
        chk("abort_busy", busy_a, 1'b0);
        chk("abort_noresp", 32'(nresp_a), 32'(n0));
        issue(1, 0, 16'h1234, '0);

        // Reset clears the sticky flag and read data
        rst_a = 1;
        #2;
        chk("rst2_err", err_a, 1'b0);
        chk("rst2_rdata", rdata_a, '0);
        @(posedge clk); #1 rst_a = 0;
        @(posedge clk); #1;

        // Reset in the middle of a write
        issue(0, 1, 16'h0400, rand_blk());
        wa = 1; aa = 16'h0400; wda = '1;
        repeat (4) @(posedge clk);
        #3 rst_a = 1;
        #1;
        chk("midrst_busy", busy_a, 1'b0);
        chk("midrst_resp", resp_a, 1'b0);
        @(posedge clk); #1 wa = 0; rst_a = 0;
        @(posedge clk); #1;
        issue(1, 0, 16'h0400, '0);
        chk("midrst_err", err_a, 1'b0);

        // Read and write together: flagged, served as read, no write
        issue(1, 1, 16'h0400, rand_blk());
        chk("illegal_err", err_a, 1'b1);
        issue(1, 0, 16'h0400, '0);

        // Minimum latency with the read held continuously
        @(posedge clk); #1;
        base = cyc;
        rb = 1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (resp_b) begin
                pulses.push_back(cyc);
                chk("b_rdata", rdata_b, '0);
            end
        end
        rb = 0;
        chk("b_pulses", 32'(pulses.size()), 32'd4);
        for (int i = 0; i < pulses.size(); i++)
            chk("b_pulse_cycle", 32'(pulses[i]), 32'(base + 2 + 3 * i));
        chk("b_err", err_b, 1'b0);

        repeat (3) @(posedge clk);
        chk("sb_empty", 32'(sbq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
